// File: rtl/ph_cache_sched.sv
// ph_cache_sched
// Ping-pong frame scheduler for the pulse-height cache. Incoming frames are
// steered into one of two PH banks. Completed frames are handed to readers
// in commit order. Word reads of the current read frame are arbitrated
// round-robin between the host and the baseline-subtraction engine.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   axi_str_rxd_*            PH frame stream in (never stalled, drops instead)
//   bank_we/waddr/wdata      registered bank write port (bank_we one-hot)
//   bank_rsel/raddr          registered bank read port (1-cycle bank latency)
//   bank_rdata0/1            bank read data
//   host_* / eng_*           word-read request/grant/valid per requester
//   rdata                    shared read data, qualified by *_rvalid
//   rd_done                  releases the current read frame
//   frame_avail, rd_len      read frame present and its word count
//   frame_seq, drop_cnt      committed / dropped frame counters
//   trunc, clr_stat          sticky oversize flag, statistics clear
//
// Writer states
//   state  | meaning
//   W_SYNC | discarding a partial frame seen after reset, waiting for tlast
//   W_IDLE | between frames, next beat starts a frame
//   W_FILL | storing a frame into the claimed bank
//   W_DROP | no bank was free at frame start, discarding until tlast
module ph_cache_sched #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] axi_str_rxd_tdata,
    input  logic          axi_str_rxd_tvalid,
    input  logic          axi_str_rxd_tlast,
    output logic          axi_str_rxd_tready,
    output logic [1:0]    bank_we,
    output logic [AW-1:0] bank_waddr,
    output logic [DW-1:0] bank_wdata,
    output logic          bank_rsel,
    output logic [AW-1:0] bank_raddr,
    input  logic [DW-1:0] bank_rdata0,
    input  logic [DW-1:0] bank_rdata1,
    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    output logic          host_gnt,
    output logic          host_rvalid,
    input  logic          eng_req,
    input  logic [AW-1:0] eng_addr,
    output logic          eng_gnt,
    output logic          eng_rvalid,
    output logic [DW-1:0] rdata,
    input  logic          rd_done,
    output logic          frame_avail,
    output logic [AW:0]   rd_len,
    output logic [15:0]   frame_seq,
    output logic [15:0]   drop_cnt,
    output logic          trunc,
    input  logic          clr_stat
);

    typedef enum logic [1:0] {W_SYNC, W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL} bstate_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    wstate_t       wstate_q, wstate_d;
    bstate_t       bst_q [2];
    bstate_t       bst_d [2];
    logic [AW:0]   len_q [2];
    logic [AW:0]   len_d [2];
    logic          wbank_q, wbank_d;
    logic [AW:0]   wcnt_q, wcnt_d;
    logic [1:0]    fifo_q, fifo_d;        // fifo_q[0] is the read bank
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [15:0]   frame_seq_q, frame_seq_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          trunc_q, trunc_d;
    logic [1:0]    we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          pri_host_q, pri_host_d;
    logic          rsel_q, rsel_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          p1_host_q, p1_host_d;
    logic          p1_eng_q, p1_eng_d;
    logic          p2_host_q, p2_host_d;
    logic          p2_eng_q, p2_eng_d;
    logic          rsel2_q, rsel2_d;

    logic          accept;
    logic          rel;
    logic          head;
    logic          any_empty;
    logic          claim;
    logic          commit;
    logic          commit_bank;
    logic [AW:0]   commit_len;
    logic          drop;
    logic          trunc_set;
    logic [1:0]    cnt_pop;

    assign axi_str_rxd_tready = !rst;
    assign accept      = axi_str_rxd_tvalid && !rst;
    assign frame_avail = (fifo_cnt_q != 2'd0);
    assign head        = fifo_q[0];
    assign rel         = rd_done && frame_avail;
    assign any_empty   = (bst_q[0] == B_EMPTY) || (bst_q[1] == B_EMPTY);
    assign claim       = (bst_q[0] == B_EMPTY) ? 1'b0 : 1'b1;

    // Tie goes to whichever requester was not granted most recently.
    assign host_gnt = frame_avail && host_req && (!eng_req || pri_host_q);
    assign eng_gnt  = frame_avail && eng_req && (!host_req || !pri_host_q);

    always_comb begin
        wstate_d    = wstate_q;
        bst_d       = bst_q;
        len_d       = len_q;
        wbank_d     = wbank_q;
        wcnt_d      = wcnt_q;
        fifo_d      = fifo_q;
        fifo_cnt_d  = fifo_cnt_q;
        frame_seq_d = frame_seq_q;
        drop_cnt_d  = drop_cnt_q;
        trunc_d     = trunc_q;
        we_d        = 2'b00;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        pri_host_d  = pri_host_q;
        rsel_d      = rsel_q;
        raddr_d     = raddr_q;
        p1_host_d   = host_gnt;
        p1_eng_d    = eng_gnt;
        p2_host_d   = p1_host_q;
        p2_eng_d    = p1_eng_q;
        rsel2_d     = rsel_q;
        commit      = 1'b0;
        commit_bank = 1'b0;
        commit_len  = '0;
        drop        = 1'b0;
        trunc_set   = 1'b0;
        cnt_pop     = fifo_cnt_q;

        case (wstate_q)
            W_SYNC: begin
                if (accept && axi_str_rxd_tlast) wstate_d = W_IDLE;
            end
            W_IDLE: begin
                if (accept) begin
                    if (any_empty) begin
                        we_d[claim] = 1'b1;
                        waddr_d     = '0;
                        wdata_d     = axi_str_rxd_tdata;
                        if (axi_str_rxd_tlast) begin
                            commit      = 1'b1;
                            commit_bank = claim;
                            commit_len  = (AW+1)'(1);
                        end else begin
                            bst_d[claim] = B_FILL;
                            wbank_d      = claim;
                            wcnt_d       = (AW+1)'(1);
                            wstate_d     = W_FILL;
                        end
                    end else if (axi_str_rxd_tlast) begin
                        drop = 1'b1;
                    end else begin
                        wstate_d = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (accept) begin
                    if (wcnt_q != DEPTH) begin
                        we_d[wbank_q] = 1'b1;
                        waddr_d       = wcnt_q[AW-1:0];
                        wdata_d       = axi_str_rxd_tdata;
                        wcnt_d        = wcnt_q + (AW+1)'(1);
                    end else begin
                        trunc_set = 1'b1;
                    end
                    if (axi_str_rxd_tlast) begin
                        commit      = 1'b1;
                        commit_bank = wbank_q;
                        commit_len  = wcnt_d;
                        wstate_d    = W_IDLE;
                    end
                end
            end
            W_DROP: begin
                if (accept && axi_str_rxd_tlast) begin
                    drop     = 1'b1;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_SYNC;
        endcase

        // Release pops before the push so a same-cycle commit lands behind
        // the surviving entry.
        if (rel) begin
            bst_d[head] = B_EMPTY;
            fifo_d[0]   = fifo_q[1];
            cnt_pop     = fifo_cnt_q - 2'd1;
        end
        fifo_cnt_d = cnt_pop;
        if (commit) begin
            bst_d[commit_bank] = B_FULL;
            len_d[commit_bank] = commit_len;
            if (cnt_pop == 2'd0) fifo_d[0] = commit_bank;
            else                 fifo_d[1] = commit_bank;
            fifo_cnt_d  = cnt_pop + 2'd1;
            frame_seq_d = frame_seq_q + 16'd1;
        end

        if (clr_stat) begin
            drop_cnt_d = '0;
            trunc_d    = 1'b0;
        end else begin
            if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
            if (trunc_set) trunc_d = 1'b1;
        end

        if (host_gnt) begin
            rsel_d     = head;
            raddr_d    = host_addr;
            pri_host_d = 1'b0;
        end else if (eng_gnt) begin
            rsel_d     = head;
            raddr_d    = eng_addr;
            pri_host_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q    <= W_SYNC;
            bst_q       <= '{B_EMPTY, B_EMPTY};
            len_q       <= '{default: '0};
            wbank_q     <= 1'b0;
            wcnt_q      <= '0;
            fifo_q      <= '0;
            fifo_cnt_q  <= '0;
            frame_seq_q <= '0;
            drop_cnt_q  <= '0;
            trunc_q     <= 1'b0;
            we_q        <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pri_host_q  <= 1'b1;
            rsel_q      <= 1'b0;
            raddr_q     <= '0;
            p1_host_q   <= 1'b0;
            p1_eng_q    <= 1'b0;
            p2_host_q   <= 1'b0;
            p2_eng_q    <= 1'b0;
            rsel2_q     <= 1'b0;
        end else begin
            wstate_q    <= wstate_d;
            bst_q       <= bst_d;
            len_q       <= len_d;
            wbank_q     <= wbank_d;
            wcnt_q      <= wcnt_d;
            fifo_q      <= fifo_d;
            fifo_cnt_q  <= fifo_cnt_d;
            frame_seq_q <= frame_seq_d;
            drop_cnt_q  <= drop_cnt_d;
            trunc_q     <= trunc_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            pri_host_q  <= pri_host_d;
            rsel_q      <= rsel_d;
            raddr_q     <= raddr_d;
            p1_host_q   <= p1_host_d;
            p1_eng_q    <= p1_eng_d;
            p2_host_q   <= p2_host_d;
            p2_eng_q    <= p2_eng_d;
            rsel2_q     <= rsel2_d;
        end
    end

    assign bank_we     = we_q;
    assign bank_waddr  = waddr_q;
    assign bank_wdata  = wdata_q;
    assign bank_rsel   = rsel_q;
    assign bank_raddr  = raddr_q;
    assign host_rvalid = p2_host_q;
    assign eng_rvalid  = p2_eng_q;
    // Bank data arrives one cycle after raddr; gate it so idle rdata is 0.
    assign rdata       = (p2_host_q || p2_eng_q) ? (rsel2_q ? bank_rdata1 : bank_rdata0) : '0;
    assign rd_len      = frame_avail ? len_q[head] : '0;
    assign frame_seq   = frame_seq_q;
    assign drop_cnt    = drop_cnt_q;
    assign trunc       = trunc_q;

endmodule

// File: tb/tb_ph_cache_sched.sv
module tb_ph_cache_sched;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast, tready;
    logic [1:0]    bank_we;
    logic [AW-1:0] bank_waddr, bank_raddr;
    logic [DW-1:0] bank_wdata, bank_rdata0, bank_rdata1, rdata;
    logic          bank_rsel;
    logic          host_req, host_gnt, host_rvalid;
    logic          eng_req, eng_gnt, eng_rvalid;
    logic [AW-1:0] host_addr, eng_addr;
    logic          rd_done, frame_avail, trunc, clr_stat;
    logic [AW:0]   rd_len;
    logic [15:0]   frame_seq, drop_cnt;

    always #5 clk = ~clk;

    ph_cache_sched #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .axi_str_rxd_tdata(tdata), .axi_str_rxd_tvalid(tvalid),
        .axi_str_rxd_tlast(tlast), .axi_str_rxd_tready(tready),
        .bank_we(bank_we), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
        .bank_rsel(bank_rsel), .bank_raddr(bank_raddr),
        .bank_rdata0(bank_rdata0), .bank_rdata1(bank_rdata1),
        .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid),
        .rdata(rdata), .rd_done(rd_done), .frame_avail(frame_avail), .rd_len(rd_len),
        .frame_seq(frame_seq), .drop_cnt(drop_cnt), .trunc(trunc), .clr_stat(clr_stat)
    );

    // Bank RAMs with one cycle read latency, plus a write counter.
    logic [DW-1:0] mem0 [256];
    logic [DW-1:0] mem1 [256];
    int we_cnt = 0;
    always @(posedge clk) begin
        if (bank_we[0]) mem0[bank_waddr] <= bank_wdata;
        if (bank_we[1]) mem1[bank_waddr] <= bank_wdata;
        bank_rdata0 <= mem0[bank_raddr];
        bank_rdata1 <= mem1[bank_raddr];
        if (!rst && bank_we != 2'b00) we_cnt <= we_cnt + 1;
    end

    // Reference model: free banks, queue of committed frames, stored words.
    bit            m_free [2];
    int            q_bank [$];
    int            q_len  [$];
    logic [DW-1:0] mdata [2][256];
    int            m_seq = 0;
    int            m_drop = 0;
    bit            m_trunc = 0;
    bit            m_pri_host = 1;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input bit rnd, input logic [DW-1:0] base,
                              input bit junk, input bit rel_last, input bit clr_last,
                              output bit rdy_ok);
        int claim;
        logic [DW-1:0] d;
        claim  = -1;
        rdy_ok = 1'b1;
        if (!junk) begin
            if (m_free[0]) claim = 0;
            else if (m_free[1]) claim = 1;
            if (claim >= 0) m_free[claim] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            tick();
            d = rnd ? DW'($urandom) : base + DW'(i);
            tvalid   = 1'b1;
            tdata    = d;
            tlast    = (i == n - 1);
            rd_done  = rel_last && (i == n - 1);
            clr_stat = clr_last && (i == n - 1);
            #1;
            if (tready !== 1'b1) rdy_ok = 1'b0;
            if (claim >= 0) begin
                if (i < 256) mdata[claim][i] = d;
                else m_trunc = 1'b1;
            end
        end
        if (!junk) begin
            if (rel_last && q_bank.size() > 0) begin
                m_free[q_bank[0]] = 1'b1;
                void'(q_bank.pop_front());
                void'(q_len.pop_front());
            end
            if (claim >= 0) begin
                q_bank.push_back(claim);
                q_len.push_back(n > 256 ? 256 : n);
                m_seq++;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
            if (clr_last) begin
                m_drop  = 0;
                m_trunc = 1'b0;
            end
        end
        tick();
        tvalid = 1'b0; tlast = 1'b0; rd_done = 1'b0; clr_stat = 1'b0; tdata = '0;
    endtask

    task automatic release_frame();
        tick();
        rd_done = 1'b1;
        if (q_bank.size() > 0) begin
            m_free[q_bank[0]] = 1'b1;
            void'(q_bank.pop_front());
            void'(q_len.pop_front());
        end
        tick();
        rd_done = 1'b0;
    endtask

    task automatic read_word(input bit eng, input logic [AW-1:0] addr, input bit rel,
                             output bit gnt_ok, output bit rv_ok,
                             output logic [DW-1:0] data, output logic rsel);
        tick();
        host_req = !eng; eng_req = eng;
        host_addr = addr; eng_addr = addr;
        rd_done = rel;
        #1;
        gnt_ok = eng ? (eng_gnt === 1'b1 && host_gnt === 1'b0)
                     : (host_gnt === 1'b1 && eng_gnt === 1'b0);
        if (q_bank.size() > 0) m_pri_host = eng;
        if (rel && q_bank.size() > 0) begin
            m_free[q_bank[0]] = 1'b1;
            void'(q_bank.pop_front());
            void'(q_len.pop_front());
        end
        tick();
        host_req = 1'b0; eng_req = 1'b0; rd_done = 1'b0;
        #1;
        rsel = bank_rsel;
        tick();
        #1;
        rv_ok = eng ? (eng_rvalid === 1'b1 && host_rvalid === 1'b0)
                    : (host_rvalid === 1'b1 && eng_rvalid === 1'b0);
        data = rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tvalid = 1'b1; tdata = DW'($urandom); tlast = 1'b1;
        host_req = 1'b1; eng_req = 1'b1; host_addr = '0; eng_addr = '0;
        rd_done = 1'b1; clr_stat = 1'b0;
        repeat (3) tick();
        #1;
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b want 0", tready); end
        checks++; if (bank_we !== 2'b00 || bank_waddr !== '0 || bank_wdata !== '0) begin
            errors++; $display("FAIL reset_wport got we=%0b wa=%0h wd=%0h want 0", bank_we, bank_waddr, bank_wdata); end
        checks++; if (bank_rsel !== 1'b0 || bank_raddr !== '0) begin
            errors++; $display("FAIL reset_rport got rsel=%0b ra=%0h want 0", bank_rsel, bank_raddr); end
        checks++; if (host_gnt !== 1'b0 || eng_gnt !== 1'b0 || host_rvalid !== 1'b0 || eng_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_arb got %0b%0b%0b%0b want 0000", host_gnt, eng_gnt, host_rvalid, eng_rvalid); end
        checks++; if (rdata !== '0 || frame_avail !== 1'b0 || rd_len !== '0) begin
            errors++; $display("FAIL reset_read got rdata=%0h avail=%0b len=%0d want 0", rdata, frame_avail, rd_len); end
        checks++; if (frame_seq !== '0 || drop_cnt !== '0 || trunc !== 1'b0) begin
            errors++; $display("FAIL reset_stats got seq=%0d drop=%0d trunc=%0b want 0", frame_seq, drop_cnt, trunc); end
        tvalid = 1'b0; tlast = 1'b0; host_req = 1'b0; eng_req = 1'b0; rd_done = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_sync();
        int w0;
        bit ok, g, v;
        logic [DW-1:0] d;
        logic rs;
        w0 = we_cnt;
        send_frame(3, 1'b1, '0, 1'b1, 1'b0, 1'b0, ok);
        checks++; if (we_cnt !== w0 || frame_avail !== 1'b0) begin
            errors++; $display("FAIL sync_junk got writes=%0d avail=%0b want 0 0", we_cnt - w0, frame_avail); end
        send_frame(4, 1'b0, DW'('hA0), 1'b0, 1'b0, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sync_tready got 0 want 1"); end
        checks++; if (frame_seq !== 16'd1 || rd_len !== 9'd4 || frame_avail !== 1'b1) begin
            errors++; $display("FAIL sync_commit got seq=%0d len=%0d avail=%0b want 1 4 1", frame_seq, rd_len, frame_avail); end
        for (int i = 0; i < 4; i++) begin
            read_word(1'b0, AW'(i), 1'b0, g, v, d, rs);
            checks++; if (!g || !v || d !== DW'('hA0 + i) || rs !== 1'b0) begin
                errors++; $display("FAIL sync_word%0d got g=%0b v=%0b d=%0h rsel=%0b want 1 1 %0h 0", i, g, v, d, rs, 'hA0 + i); end
        end
        release_frame();
        #1;
        checks++; if (frame_avail !== 1'b0) begin errors++; $display("FAIL sync_release got %0b want 0", frame_avail); end
    endtask

    task automatic test_pingpong();
        bit ok, all_ok, g, v;
        logic [DW-1:0] d, exp_d;
        logic rs;
        logic [AW-1:0] a;
        all_ok = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_frame(8, 1'b1, '0, 1'b0, 1'b0, 1'b0, ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok) begin errors++; $display("FAIL pp_tready got 0 want 1"); end
        checks++; if (drop_cnt !== 16'(m_drop) || m_drop != 1) begin
            errors++; $display("FAIL pp_drop got %0d want 1", drop_cnt); end
        checks++; if (frame_seq !== 16'(m_seq) || rd_len !== 9'd8) begin
            errors++; $display("FAIL pp_commit got seq=%0d len=%0d want %0d 8", frame_seq, rd_len, m_seq); end
        for (int b = 0; b < 2; b++) begin
            a = AW'($urandom_range(0, 7));
            exp_d = mdata[q_bank[0]][a];
            read_word(1'b1, a, 1'b0, g, v, d, rs);
            checks++; if (!g || !v || d !== exp_d || rs !== 1'(b)) begin
                errors++; $display("FAIL pp_bank%0d got g=%0b v=%0b d=%0h rsel=%0b want 1 1 %0h %0d", b, g, v, d, rs, exp_d, b); end
            release_frame();
        end
        #1;
        checks++; if (frame_avail !== 1'b0) begin errors++; $display("FAIL pp_empty got %0b want 0", frame_avail); end
    endtask

    task automatic test_arb();
        bit ok, g, v, pend_ok, pri;
        logic [DW-1:0] d;
        logic rs;
        bit w [4];
        logic [AW-1:0] ad [4];
        int hb;
        pend_ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(); host_req = 1'b1; host_addr = '0; #1;
            if (host_gnt !== 1'b0) pend_ok = 1'b0;
        end
        host_req = 1'b0;
        checks++; if (!pend_ok) begin errors++; $display("FAIL arb_no_frame got gnt=1 want 0"); end
        send_frame(16, 1'b1, '0, 1'b0, 1'b0, 1'b0, ok);
        read_word(1'b1, AW'(3), 1'b0, g, v, d, rs);
        checks++; if (!g || !v || d !== mdata[q_bank[0]][3]) begin
            errors++; $display("FAIL arb_single got g=%0b v=%0b d=%0h want 1 1 %0h", g, v, d, mdata[q_bank[0]][3]); end
        pri = m_pri_host;
        hb = q_bank[0];
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c < 4) begin
                host_req = 1'b1; eng_req = 1'b1;
                host_addr = AW'($urandom_range(0, 15));
                eng_addr  = AW'($urandom_range(0, 15));
            end else begin
                host_req = 1'b0; eng_req = 1'b0;
            end
            #1;
            if (c < 4) begin
                w[c]  = !pri;
                ad[c] = w[c] ? eng_addr : host_addr;
                checks++; if (host_gnt !== !w[c] || eng_gnt !== w[c]) begin
                    errors++; $display("FAIL arb_gnt%0d got h=%0b e=%0b want h=%0b e=%0b", c, host_gnt, eng_gnt, !w[c], w[c]); end
                pri = w[c];
            end
            if (c >= 2) begin
                checks++; if (host_rvalid !== !w[c-2] || eng_rvalid !== w[c-2] || rdata !== mdata[hb][ad[c-2]]) begin
                    errors++; $display("FAIL arb_rd%0d got hv=%0b ev=%0b d=%0h want %0b %0b %0h",
                                       c - 2, host_rvalid, eng_rvalid, rdata, !w[c-2], w[c-2], mdata[hb][ad[c-2]]); end
            end
        end
        m_pri_host = pri;
        release_frame();
    endtask

    task automatic test_trunc();
        int w0;
        bit ok, g, v;
        logic [DW-1:0] base, d;
        logic rs;
        int idx [3] = '{0, 43, 255};
        w0 = we_cnt;
        base = DW'($urandom);
        send_frame(300, 1'b0, base, 1'b0, 1'b0, 1'b0, ok);
        checks++; if (we_cnt - w0 != 256) begin errors++; $display("FAIL trunc_writes got %0d want 256", we_cnt - w0); end
        checks++; if (rd_len !== 9'd256 || trunc !== 1'b1 || trunc !== m_trunc) begin
            errors++; $display("FAIL trunc_flag got len=%0d trunc=%0b want 256 1", rd_len, trunc); end
        for (int k = 0; k < 3; k++) begin
            read_word(1'(k & 1), AW'(idx[k]), 1'b0, g, v, d, rs);
            checks++; if (!g || !v || d !== base + DW'(idx[k])) begin
                errors++; $display("FAIL trunc_word%0d got %0h want %0h", idx[k], d, base + DW'(idx[k])); end
        end
        release_frame();
    endtask

    task automatic test_same_cycle();
        bit ok, g, v;
        logic [DW-1:0] d, exp_d;
        logic rs;
        int eb;
        logic [AW-1:0] a;
        send_frame(6, 1'b1, '0, 1'b0, 1'b0, 1'b0, ok);
        send_frame(5, 1'b1, '0, 1'b0, 1'b1, 1'b0, ok);
        checks++; if (frame_avail !== 1'b1 || rd_len !== 9'd5) begin
            errors++; $display("FAIL same_commit got avail=%0b len=%0d want 1 5", frame_avail, rd_len); end
        a = AW'($urandom_range(0, 4));
        exp_d = mdata[q_bank[0]][a]; eb = q_bank[0];
        read_word(1'b0, a, 1'b0, g, v, d, rs);
        checks++; if (!g || !v || d !== exp_d || rs !== 1'(eb) || eb != 1) begin
            errors++; $display("FAIL same_switch got d=%0h rsel=%0b want %0h 1", d, rs, exp_d); end
        send_frame(7, 1'b1, '0, 1'b0, 1'b0, 1'b0, ok);
        checks++; if (drop_cnt !== 16'(m_drop) || frame_seq !== 16'(m_seq)) begin
            errors++; $display("FAIL same_reclaim got drop=%0d seq=%0d want %0d %0d", drop_cnt, frame_seq, m_drop, m_seq); end
        // grant coincides with release: data still comes from the released bank
        a = AW'($urandom_range(0, 4));
        exp_d = mdata[q_bank[0]][a]; eb = q_bank[0];
        read_word(1'b1, a, 1'b1, g, v, d, rs);
        checks++; if (!g || !v || d !== exp_d || rs !== 1'(eb)) begin
            errors++; $display("FAIL same_gnt_rel got d=%0h rsel=%0b want %0h %0d", d, rs, exp_d, eb); end
        a = AW'($urandom_range(0, 6));
        exp_d = mdata[q_bank[0]][a]; eb = q_bank[0];
        read_word(1'b0, a, 1'b0, g, v, d, rs);
        checks++; if (rd_len !== 9'd7 || d !== exp_d || rs !== 1'(eb) || eb != 0) begin
            errors++; $display("FAIL same_next got len=%0d d=%0h rsel=%0b want 7 %0h 0", rd_len, d, rs, exp_d); end
        release_frame();
    endtask

    task automatic test_single_clr();
        bit ok, g, v;
        logic [DW-1:0] d, exp_d;
        logic rs;
        send_frame(1, 1'b1, '0, 1'b0, 1'b0, 1'b0, ok);
        exp_d = mdata[q_bank[0]][0];
        checks++; if (rd_len !== 9'd1 || frame_seq !== 16'(m_seq)) begin
            errors++; $display("FAIL single_len got len=%0d seq=%0d want 1 %0d", rd_len, frame_seq, m_seq); end
        read_word(1'b0, '0, 1'b0, g, v, d, rs);
        checks++; if (!g || !v || d !== exp_d) begin errors++; $display("FAIL single_word got %0h want %0h", d, exp_d); end
        send_frame(1, 1'b1, '0, 1'b0, 1'b0, 1'b0, ok);
        send_frame(1, 1'b1, '0, 1'b0, 1'b0, 1'b0, ok);
        checks++; if (drop_cnt !== 16'(m_drop)) begin
            errors++; $display("FAIL single_drop got %0d want %0d", drop_cnt, m_drop); end
        send_frame(1, 1'b1, '0, 1'b0, 1'b0, 1'b1, ok);
        checks++; if (drop_cnt !== 16'd0 || trunc !== 1'b0) begin
            errors++; $display("FAIL clr_drop got drop=%0d trunc=%0b want 0 0", drop_cnt, trunc); end
        release_frame();
        release_frame();
        send_frame(2, 1'b1, '0, 1'b0, 1'b0, 1'b0, ok);
        checks++; if (rd_len !== 9'd2 || frame_seq !== 16'(m_seq)) begin
            errors++; $display("FAIL single_after got len=%0d seq=%0d want 2 %0d", rd_len, frame_seq, m_seq); end
        release_frame();
    endtask

    task automatic test_random();
        bit ok, g, v, who;
        logic [DW-1:0] d, exp_d;
        logic rs;
        int eb;
        logic [AW-1:0] a;
        int op;
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                send_frame($urandom_range(1, 12), 1'b1, '0, 1'b0,
                           (q_bank.size() > 0) && ($urandom_range(0, 3) == 0), 1'b0, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rnd_tready%0d got 0 want 1", k); end
            end else if (op == 2 && q_bank.size() > 0) begin
                a = AW'($urandom_range(0, q_len[0] - 1));
                exp_d = mdata[q_bank[0]][a]; eb = q_bank[0];
                who = 1'($urandom_range(0, 1));
                read_word(who, a, 1'b0, g, v, d, rs);
                checks++; if (!g || !v || d !== exp_d || rs !== 1'(eb)) begin
                    errors++; $display("FAIL rnd_read%0d got g=%0b v=%0b d=%0h rsel=%0b want 1 1 %0h %0d", k, g, v, d, rs, exp_d, eb); end
            end else begin
                release_frame();
            end
            #1;
            checks++; if (frame_seq !== 16'(m_seq) || drop_cnt !== 16'(m_drop) || frame_avail !== (q_bank.size() > 0)) begin
                errors++; $display("FAIL rnd_stat%0d got seq=%0d drop=%0d avail=%0b want %0d %0d %0b",
                                   k, frame_seq, drop_cnt, frame_avail, m_seq, m_drop, q_bank.size() > 0); end
            if (q_bank.size() > 0) begin
                checks++; if (rd_len !== 9'(q_len[0])) begin
                    errors++; $display("FAIL rnd_len%0d got %0d want %0d", k, rd_len, q_len[0]); end
            end
        end
        while (q_bank.size() > 0) release_frame();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        m_free[0] = 1'b1;
        m_free[1] = 1'b1;
        test_reset();
        test_sync();
        test_pingpong();
        test_arb();
        test_trunc();
        test_same_cycle();
        test_single_clr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ph_cache_sched.md
# ph_cache_sched

Ping-pong frame scheduler for the pulse-height cache. It accepts MAROC pulse-height frames on an AXI-Stream slave and steers each frame into one of two 256-word PH banks. It tracks the state of each bank and hands completed frames to readers in commit order. It also arbitrates word reads of the current frame between the host (AXI-Lite register path) and the baseline-subtraction engine.

## Interface
Parameters:
- AW, 8, bank address width; bank depth is 2^AW words
- DW, 32, data word width

Ports:
- clk  in  1  system clock; every port is synchronous to it
- rst  in  1  synchronous, active-high reset
- axi_str_rxd_tdata  in  DW  PH stream data
- axi_str_rxd_tvalid  in  1  stream valid
- axi_str_rxd_tlast  in  1  last beat of frame
- axi_str_rxd_tready  out  1  stream ready
- bank_we  out  2  one-hot write enable, bit b writes bank b
- bank_waddr  out  AW  write address
- bank_wdata  out  DW  write data
- bank_rsel  out  1  bank being read
- bank_raddr  out  AW  read address (bank read latency is 1 cycle)
- bank_rdata0 / bank_rdata1  in  DW  bank read data
- host_req  in  1  host word-read request, held until host_gnt
- host_addr  in  AW  host word index
- host_gnt  out  1  host request accepted
- host_rvalid  out  1  host read data valid
- eng_req / eng_addr / eng_gnt / eng_rvalid  same as host_* for the baseline engine
- rdata  out  DW  shared read data, qualified by host_rvalid or eng_rvalid
- rd_done  in  1  engine pulse: release the current read frame
- frame_avail  out  1  at least one bank is FULL
- rd_len  out  AW+1  word count of the current read frame (1..2^AW)
- frame_seq  out  16  count of committed frames, wraps
- drop_cnt  out  16  count of dropped frames, saturates at 0xFFFF
- trunc  out  1  sticky flag: a frame exceeded 2^AW words
- clr_stat  in  1  clears drop_cnt and trunc

## Operation
- Each bank has a state: EMPTY, FILL or FULL. A two-entry commit FIFO records which bank holds the oldest frame; that bank is the read bank.
- Writer FSM states: W_SYNC, W_IDLE, W_FILL, W_DROP.
  - W_SYNC is entered on reset. Beats are accepted and discarded. A tlast beat moves the FSM to W_IDLE, so a partial frame in flight at reset is never stored.
  - W_IDLE: the first accepted beat starts a frame. If a bank is EMPTY, the lowest-numbered EMPTY bank is claimed, the beat is written at address 0, and the FSM goes to W_FILL. If no bank is EMPTY, the beat is discarded and the FSM goes to W_DROP.
  - W_FILL: each beat is written at the next address.
    - Beats beyond 2^AW words are discarded and trunc is set.
    - The tlast beat commits the frame: the bank becomes FULL, it is pushed to the commit FIFO, its length is latched (min of count and 2^AW), frame_seq increments, and the FSM goes to W_IDLE.
  - W_DROP: beats are discarded. On tlast, drop_cnt increments (saturating) and the FSM goes to W_IDLE.
  - A single-beat frame (tvalid and tlast together in W_IDLE) commits with length 1 in the same cycle. If no bank is EMPTY it is dropped, and drop_cnt increments in that same cycle without entering W_DROP.
- axi_str_rxd_tready is 1 in every writer state and 0 only during reset. Frames are never stalled; they are dropped instead.
- Read arbiter:
  - Requests are considered only while frame_avail is 1. Requests made while frame_avail is 0 stay pending.
  - At most one grant per cycle, round-robin between host and engine; the host wins the first tie after reset.
  - A requester's address is masked to AW bits. Reads at or beyond rd_len return the bank contents without error.
- Release: rd_done pops the commit FIFO and sets that bank to EMPTY. rd_done while frame_avail is 0 is ignored.
- Simultaneous commit and release: both take effect in the same cycle. The released bank cannot be claimed until the next cycle.
- Grant and release in the same cycle: the grant still reads the released bank, and its data is returned normally.
- clr_stat and a drop in the same cycle: clear wins, so drop_cnt becomes 0.

## Timing
- Stream to bank write latency is 1 cycle: bank_we, bank_waddr and bank_wdata are registered from the accepted beat.
- A frame whose tlast is accepted in cycle N sets frame_avail at N+1. When that frame becomes the read bank, rd_len is valid at N+1.
- Read latency is 2 cycles:
  - req sampled in cycle N, gnt pulses in N (combinational from registered arbiter state).
  - bank_rsel and bank_raddr are registered and driven in N+1.
  - rvalid pulses and rdata is valid in N+2.
  - Back-to-back grants give one word per cycle.
- rd_done in cycle N: the next frame (if any) is presented at N+1, and the freed bank is EMPTY at N+1.
- Reset values:
  - outputs: axi_str_rxd_tready=0, bank_we=0, bank_waddr=0, bank_wdata=0, bank_rsel=0, bank_raddr=0, host_gnt=0, eng_gnt=0, host_rvalid=0, eng_rvalid=0, rdata=0, frame_avail=0, rd_len=0, frame_seq=0, drop_cnt=0, trunc=0.
  - internal: both banks EMPTY, writer FSM in W_SYNC.

## Test plan
- Sync after reset: three beats with tlast on the third, then a 4-word frame 0xA0..0xA3. The first three beats are not stored; frame_seq=1, rd_len=4, and bank 0 holds 0xA0..0xA3.
- Ping-pong and overflow: three 8-word frames with no rd_done. The first two commit to bank 0 then bank 1; the third is dropped, drop_cnt=1, and tready stays 1 throughout.
- Arbitration: host_req and eng_req held for 4 cycles. Grants alternate host, engine, host, engine; each rvalid appears 2 cycles after its gnt with the correct word.
- Truncation: a 300-word frame with AW=8. rd_len=256, trunc=1, and words 256..299 are not written.
- Release and commit in the same cycle: rd_done coincides with the tlast of the next frame. frame_avail stays 1, the read bank switches, and the freed bank is claimed by the following frame.
- Single-beat frame and clr_stat: a 1-beat frame gives rd_len=1. clr_stat in the same cycle as a drop leaves drop_cnt=0.
